// File: rtl/sync_debounce_bank.sv
// Bank of independent input conditioners: per-channel synchroniser, debounce counter,
// registered edge pulses and sticky, individually clearable edge-event flags.
module sync_debounce_bank #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned EDGE_SEL        = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sig,
  input  logic [CHANNELS-1:0] evt_clr,
  output logic [CHANNELS-1:0] sigSync,
  output logic [CHANNELS-1:0] rising_ind,
  output logic [CHANNELS-1:0] falling_ind,
  output logic [CHANNELS-1:0] evt_pend,
  output logic                any_evt
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam bit CapRise = (EDGE_SEL == 0) || (EDGE_SEL == 2);
  localparam bit CapFall = (EDGE_SEL == 1) || (EDGE_SEL == 2);

  // sync_q[0] is the first stage; sync_q[SYNC_STAGES-1] feeds the debouncer.
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]                  s;
  logic [CHANNELS-1:0]                  db_q, db_d;
  logic [CHANNELS-1:0][CntW-1:0]        cnt_q, cnt_d;
  logic [CHANNELS-1:0]                  rise_q, rise_d;
  logic [CHANNELS-1:0]                  fall_q, fall_d;
  logic [CHANNELS-1:0]                  pend_q, pend_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    db_d   = db_q;
    cnt_d  = cnt_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s[i] == db_q[i]) begin
        // Level back at the accepted value: any partial window is thrown away.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        db_d[i]   = s[i];
        cnt_d[i]  = '0;
        rise_d[i] = s[i];
        fall_d[i] = ~s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    // Set has priority over clear so an event arriving with a clear is not lost.
    pend_d = (pend_q & ~evt_clr)
           | (CapRise ? rise_d : '0)
           | (CapFall ? fall_d : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      db_q   <= '0;
      cnt_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      pend_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      pend_q <= pend_d;
    end
  end

  assign sigSync     = db_q;
  assign rising_ind  = rise_q;
  assign falling_ind = fall_q;
  assign evt_pend    = pend_q;
  assign any_evt     = |pend_q;

endmodule

// File: doc/sync_debounce_bank.md
SYNC_DEBOUNCE_BANK -- requirements
Module: sync_debounce_bank

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, number of independent input channels (>=1).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, synchroniser flops per channel (>=2).
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive cycles a new level must persist before acceptance (>=1).
REQ-004 The block SHALL have parameter EDGE_SEL, default 2, event capture mode: 0 rising only, 1 falling only, 2 both.
REQ-005 The block SHALL have port clk, input, 1, single clock for all logic.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port sig, input, CHANNELS, asynchronous raw inputs.
REQ-008 The block SHALL have port evt_clr, input, CHANNELS, per-channel pending-event clear, synchronous to clk.
REQ-009 The block SHALL have port sigSync, output, CHANNELS, debounced synchronised level.
REQ-010 The block SHALL have port rising_ind, output, CHANNELS, one-cycle pulse on accepted 0->1.
REQ-011 The block SHALL have port falling_ind, output, CHANNELS, one-cycle pulse on accepted 1->0.
REQ-012 The block SHALL have port evt_pend, output, CHANNELS, sticky captured edge events.
REQ-013 The block SHALL have port any_evt, output, 1, OR-reduction of evt_pend.

Function
REQ-014 Each channel SHALL pass sig[i] through a chain of SYNC_STAGES flops; s[i] denotes the last stage; no logic SHALL sit between stages.
REQ-015 Each channel SHALL hold a debounced state db[i] (driven on sigSync[i]) and a counter cnt[i] of width max(1, clog2(DEBOUNCE_CYCLES)).
REQ-016 Per clock edge: if s[i]==db[i], cnt[i] SHALL load 0; else if cnt[i]==DEBOUNCE_CYCLES-1, db[i] SHALL load s[i] and cnt[i] SHALL load 0; else cnt[i] SHALL increment by 1.
REQ-017 Any cycle in which s[i] returns to db[i] before acceptance SHALL discard accumulated count (bounce restarts the window).
REQ-018 An input level stable from the first sampling edge SHALL appear on sigSync[i] at edge SYNC_STAGES+DEBOUNCE_CYCLES (DEBOUNCE_CYCLES=1 gives SYNC_STAGES+1).
REQ-019 rising_ind[i] SHALL be a registered output, high for exactly the one cycle following the edge at which db[i] loads 0->1; falling_ind[i] likewise for 1->0; never both high.
REQ-020 evt_pend[i] SHALL set at the same edge db[i] changes when the change matches EDGE_SEL, and hold until cleared.
REQ-021 evt_clr[i] high at an edge SHALL clear evt_pend[i]; simultaneous set and clear SHALL leave evt_pend[i] set.
REQ-022 evt_clr[i] SHALL not affect sync chain, db, cnt or pulse outputs of any channel.
REQ-023 any_evt SHALL be combinational OR of evt_pend, changing in the same cycle as evt_pend.
REQ-024 Channels SHALL be fully independent; simultaneous events on multiple channels SHALL all be captured.
REQ-025 cnt[i] SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap-around).

Reset
REQ-026 While reset is high, all sync flops, db, cnt, rising_ind, falling_ind and evt_pend SHALL be 0 immediately, independent of clk; sigSync=0, any_evt=0.
REQ-027 Reset asserted mid-debounce SHALL discard the partial count; after release a held-high input SHALL require the full SYNC_STAGES+DEBOUNCE_CYCLES edges again.
REQ-028 An input held high through reset release SHALL produce rising_ind and, for EDGE_SEL 0 or 2, an evt_pend set after qualification.

Verification (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_SEL=2)
REQ-029 Assert reset with sig=4'hF mid-clock -> all outputs 0 without a clock edge.
REQ-030 sig[0] 0->1 held -> sigSync[0]=1 at edge 6, rising_ind[0]=1 for one cycle only, evt_pend[0]=1, any_evt=1.
REQ-031 sig[1] high 3 cycles then low -> sigSync[1], rising_ind[1], evt_pend[1] stay 0.
REQ-032 sig[2] pattern 1,1,1,0,1,1,1,1 -> sigSync[2] rises 6 edges after the 0->1 following the bounce, not before.
REQ-033 evt_clr[0]=1 in the same cycle as a falling acceptance on ch0 -> evt_pend[0] remains 1; next evt_clr[0] alone -> 0, any_evt=0.
REQ-034 Reset pulse at edge 4 of a ch3 qualification, sig[3] held high -> sigSync[3] rises 6 edges after reset release.
